// File: rtl/cc1200_spi_arb.sv
// CC1200 SPI arbiter: shares one SPI byte engine between host registers (port 0) and the TX stream (port 1).
// Ports: clk, rst (sync, active-high), reqN_valid/byte/last/ready/rvalid, rdata,
//   spi_start/stop/data, spi_busy/load_next/rdata, grant, underflow.
// Optional: define CC1200_ARB_TIMEOUT_EN to abort an owner stalled for TIMEOUT_CYCLES.
module cc1200_spi_arb #(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_byte,
  input  logic       req0_last,
  output logic       req0_ready,
  output logic       req0_rvalid,
  input  logic       req1_valid,
  input  logic [7:0] req1_byte,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       req1_rvalid,
  output logic [7:0] rdata,
  output logic       spi_start,
  output logic       spi_stop,
  output logic [7:0] spi_data,
  input  logic       spi_busy,
  input  logic       spi_load_next,
  input  logic [7:0] spi_rdata,
  output logic [1:0] grant,
  output logic       underflow
);

  if (TIMEOUT_CYCLES < 1 || GAP_CYCLES < 0) begin : g_bad_param
    $error("cc1200_spi_arb: TIMEOUT_CYCLES must be >= 1, GAP_CYCLES >= 0");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_XFER,
    S_DRAIN,
    S_GAP
  } state_t;

  // GAP lasts GAP_CYCLES cycles; 0 and 1 both give a single GAP cycle.
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam bit GAP_SHORT = (GAP_CYCLES <= 1);
  localparam logic [GW-1:0] GAP_LAST =
    GAP_SHORT ? '0 : GW'(GAP_CYCLES - 1);

  state_t        state;
  logic          prio1;
  logic [GW-1:0] gap_cnt;
  logic          gap_done;

  logic       own_valid;
  logic [7:0] own_byte;
  logic       own_last;
  logic       pick1;
  logic       rdy;
  logic       rv;
  logic       accept;

  assign own_valid = grant[1] ? req1_valid : req0_valid;
  assign own_byte  = grant[1] ? req1_byte  : req0_byte;
  assign own_last  = grant[1] ? req1_last  : req0_last;

  // prio1 is set after port 0 wins, so port 1 takes the next tie.
  assign pick1 = req1_valid & (~req0_valid | prio1);

  assign gap_done = GAP_SHORT || (gap_cnt == GAP_LAST);

  always_comb begin
    spi_start = 1'b0;
    spi_data  = 8'h00;
    rdy       = 1'b0;
    rv        = 1'b0;
    accept    = 1'b0;
    unique case (state)
      S_START: begin
        spi_start = 1'b1;
        spi_data  = own_byte;
        rdy       = 1'b1;
      end
      S_XFER: begin
        rv = spi_load_next;
        if (spi_load_next && own_valid) begin
          spi_data = own_byte;
          rdy      = 1'b1;
          accept   = 1'b1;
        end
      end
      S_DRAIN: rv = spi_load_next;
      default: ;
    endcase
  end

  assign req0_ready  = rdy & grant[0];
  assign req1_ready  = rdy & grant[1];
  assign req0_rvalid = rv & grant[0];
  assign req1_rvalid = rv & grant[1];
  assign rdata       = rv ? spi_rdata : 8'h00;

`ifdef CC1200_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      grant     <= 2'b00;
      prio1     <= 1'b0;
      spi_stop  <= 1'b0;
      underflow <= 1'b0;
      gap_cnt   <= '0;
`ifdef CC1200_ARB_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          // An engine left busy by a reset is waited out here.
          if (!spi_busy && (req0_valid || req1_valid)) begin
            grant <= pick1 ? 2'b10 : 2'b01;
            prio1 <= ~pick1;
            state <= S_START;
          end
        end
        S_START: begin
          if (own_last) begin
            spi_stop <= 1'b1;
            state    <= S_DRAIN;
          end else begin
            state <= S_XFER;
          end
`ifdef CC1200_ARB_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        S_XFER: begin
          if (spi_load_next && !own_valid) begin
            underflow <= 1'b1;
          end
          if (accept && own_last) begin
            spi_stop <= 1'b1;
            state    <= S_DRAIN;
          end
`ifdef CC1200_ARB_TIMEOUT_EN
          else if (own_valid) begin
            to_cnt <= '0;
          end else if (to_cnt == TO_LAST) begin
            spi_stop  <= 1'b1;
            underflow <= 1'b1;
            state     <= S_DRAIN;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        S_DRAIN: begin
          if (!spi_busy) begin
            spi_stop <= 1'b0;
            gap_cnt  <= '0;
            state    <= S_GAP;
          end
        end
        S_GAP: begin
          // Owner keeps the grant until the gap has elapsed.
          if (gap_done) begin
            grant <= 2'b00;
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
